// File: rtl/seq_shift_unit.sv
// ============================================================================
//  Module      : seq_shift_unit
//  Description : Multi-cycle shift/rotate engine with valid/ready request and
//                response channels; moves the operand one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [1:0]     c_MODE_ARITH = 2'b01;
    localparam logic [1:0]     c_MODE_ROT   = 2'b10;
    localparam logic [SHW-1:0] c_CNT_ONE    = SHW'(1);
    localparam logic [SHW-1:0] c_CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_out_data;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] w_step;

    // One-position step; reserved mode 11 falls through to logical.
    always_comb begin
        w_step = r_data;
        if (r_mode == c_MODE_ROT) begin
            if (r_dir) w_step = {r_data[0], r_data[WIDTH-1:1]};
            else       w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        end else if (r_dir) begin
            if (r_mode == c_MODE_ARITH) w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            else                        w_step = {1'b0, r_data[WIDTH-1:1]};
        end else begin
            w_step = {r_data[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_mode      <= 2'b00;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data     <= in_data;
                        r_cnt      <= in_amt;
                        r_dir      <= in_dir;
                        r_mode     <= in_mode;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (in_amt == c_CNT_ZERO) begin
                            r_state     <= S_DONE;
                            r_out_data  <= in_data;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - c_CNT_ONE;
                    // The result register is loaded only as the last step lands,
                    // so it keeps the previous result throughout SHIFT.
                    if (r_cnt == c_CNT_ONE) begin
                        r_state     <= S_DONE;
                        r_out_data  <= w_step;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// ============================================================================
//  Module      : tb_seq_shift_unit
//  Description : Randomized self-checking bench for seq_shift_unit against a
//                whole-amount arithmetic shift/rotate reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int n_total = 0;
    int n_bad   = 0;

    seq_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole-amount reference: shifts by the full amount at once.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a,
                                              input logic dir, input logic [1:0] mode);
        logic [63:0] dd;
        dd = {d, d};
        if (mode == 2'b10) begin
            if (dir) begin dd = dd >> a; return dd[31:0];  end
            else     begin dd = dd << a; return dd[63:32]; end
        end
        if (!dir)           return d << a;
        if (mode == 2'b01)  return 32'($signed(d) >>> a);
        return d >> a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE, checks latency and result, optionally
    // stalling the response for `stall` cycles before consuming it.
    task automatic run_op(input string tag, input logic [31:0] d, input int a,
                          input logic dir, input logic [1:0] mode, input int stall,
                          output logic [31:0] res);
        logic [31:0] exp;
        int          lat;
        exp = ref_shift(d, a, dir, mode);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = SHW'(a);
        in_dir    = dir;
        in_mode   = mode;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = SHW'($urandom);
        in_dir   = 1'($urandom);
        in_mode  = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 2 * WIDTH) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'(a + 1));
        check_val({tag, "_data"}, out_data, exp);
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        res = out_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_val({tag, "_hold"}, out_data, exp);
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_val({tag, "_release"}, 32'(out_valid), 32'd0);
        check_val({tag, "_idle"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] d;
        logic [31:0] exp2;
        int          lat;
        int          stray;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0;
        in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick();

        run_op("t1_lsl", 32'h0000_00F1, 4, 1'b0, 2'b00, 0, r0);
        check_val("t1_abs", r0, 32'h0000_0F10);
        run_op("t2_asr", 32'h8000_0000, 31, 1'b1, 2'b01, 0, r0);
        check_val("t2_asr_abs", r0, 32'hFFFF_FFFF);
        run_op("t2_lsr", 32'h8000_0000, 31, 1'b1, 2'b00, 0, r0);
        check_val("t2_lsr_abs", r0, 32'h0000_0001);
        run_op("t3_ror", 32'h0000_0001, 1, 1'b1, 2'b10, 0, r0);
        check_val("t3_ror_abs", r0, 32'h8000_0000);
        run_op("t3_rol", 32'h8000_0001, 4, 1'b0, 2'b10, 0, r0);
        check_val("t3_rol_abs", r0, 32'h0000_0018);
        for (int m = 0; m < 4; m++) begin
            run_op("t4_amt0", 32'hDEAD_BEEF, 0, 1'(m), 2'(m), 0, r0);
            check_val("t4_amt0_abs", r0, 32'hDEAD_BEEF);
        end
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            run_op("t4_m11", d, int'($urandom_range(1, 31)), 1'(k), 2'b11, 0, r0);
            run_op("t4_m00", d, int'(u_dut.r_cnt) + 0, 1'(k), 2'b00, 0, r1);
        end

        // Randomized sweep with random response stalls.
        for (int k = 0; k < 40; k++) begin
            run_op("rnd", $urandom, int'($urandom_range(0, WIDTH - 1)), 1'($urandom),
                   2'($urandom), int'($urandom_range(0, 3)), r0);
        end

        // Backpressure with a competing request held on the input.
        d = 32'h1234_5678;
        exp2 = ref_shift(32'hCAFE_F00D, 3, 1'b1, 2'b01);
        in_valid = 1'b1; in_data = d; in_amt = 5'd2; in_dir = 1'b0; in_mode = 2'b00;
        out_ready = 1'b0;
        tick();
        in_data = 32'hCAFE_F00D; in_amt = 5'd3; in_dir = 1'b1; in_mode = 2'b01;
        lat = 1;
        while (!out_valid && lat < 2 * WIDTH) begin tick(); lat++; end
        check_val("bp_latency", 32'(lat), 32'd3);
        check_val("bp_data", out_data, 32'h48D1_59E0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("bp_hold", out_data, 32'h48D1_59E0);
            check_val("bp_no_accept", 32'(in_ready), 32'd0);
            check_val("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_val("bp_idle_ready", 32'(in_ready), 32'd1);
        check_val("bp_idle_valid", 32'(out_valid), 32'd0);
        tick();
        check_val("bp_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 2 * WIDTH) begin tick(); lat++; end
        check_val("bp_second_latency", 32'(lat), 32'd4);
        check_val("bp_second_data", out_data, exp2);
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a long shift.
        in_valid = 1'b1; in_data = 32'hFFFF_0000; in_amt = 5'd20; in_dir = 1'b0; in_mode = 2'b00;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check_val("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ready", 32'(in_ready), 32'd1);
        check_val("mid_rst_data", out_data, 32'd0);
        out_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) stray++;
        end
        check_val("mid_rst_no_stale", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
